// File: rtl/hsv_core_pkg.sv
// Shared core helpers: index-width sizing and modular index arithmetic used by
// arbiters and schedulers across the core.
package hsv_core_pkg;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Single-step modular wrap: v is known to be below 2*n.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/hsv_core_rr_pick.sv
// Combinational round-robin pick: rotates the request vector so the entry after
// `last` sits at bit 0, then priority-encodes the lowest set bit.
module hsv_core_rr_pick
    import hsv_core_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IdBits  = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdBits-1:0]  last,
    output logic [IdBits-1:0]  grant,
    output logic               any
);

    int                 start_s;
    int                 offset_s;
    logic               any_s;
    logic [NUM_REQ-1:0] rot_s;

    // First candidate follows the previous winner; NUM_REQ need not be a power of two.
    always_comb begin
        start_s = wrap_idx(int'(last) + 32'sd1, NUM_REQ);
    end

    // Rotate requests so priority order becomes plain bit order.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot_s[i] = req[wrap_idx(start_s + i, NUM_REQ)];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        offset_s = 32'sd0;
        any_s    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                offset_s = i;
                any_s    = 1'b1;
            end else begin
                offset_s = offset_s;
                any_s    = any_s;
            end
        end
    end

    // Undo the rotation to recover the absolute requester index.
    always_comb begin
        grant = IdBits'(wrap_idx(start_s + offset_s, NUM_REQ));
        any   = any_s;
    end

endmodule

// File: rtl/hsv_core_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready channel between NUM_REQ
// producers, with per-owner lock to keep multi-beat transfers contiguous.
module hsv_core_rr_arbiter
    import hsv_core_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  NUM_REQ = 4,
    localparam int IdBits  = idx_bits(NUM_REQ)
) (
    input  logic                            clk_core,
    input  logic                            rst_core,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              valid_i,
    output logic [NUM_REQ-1:0]              ready_o,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   in,
    input  logic [NUM_REQ-1:0]              lock_i,
    input  logic                            ready_i,
    output logic                            valid_o,
    output logic [WIDTH-1:0]                out,
    output logic [IdBits-1:0]               out_id
);

    typedef logic [NUM_REQ-1:0][WIDTH-1:0] payload_arr_t;

    localparam logic [IdBits-1:0] LastIdx = IdBits'(NUM_REQ - 32'sd1);

    payload_arr_t        in_s;
    logic                valid_r;
    logic [WIDTH-1:0]    out_r;
    logic [IdBits-1:0]   out_id_r;
    logic [IdBits-1:0]   last_grant_r;
    logic                locked_r;

    logic                accept_s;
    logic [IdBits-1:0]   pick_grant_s;
    logic                pick_any_s;
    logic [IdBits-1:0]   grant_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic                fire_s;
    logic                lock_next_s;

    assign in_s = in;

    hsv_core_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdBits  (IdBits)
    ) u_pick (
        .req   (valid_i),
        .last  (last_grant_r),
        .grant (pick_grant_s),
        .any   (pick_any_s)
    );

    // Output stage takes a new beat when empty or when the current one drains.
    always_comb begin
        accept_s = ~valid_r | ready_i;
    end

    // A locked owner keeps the grant regardless of who else is requesting.
    always_comb begin
        if (locked_r) begin
            grant_s = last_grant_r;
        end else begin
            grant_s = pick_grant_s;
        end
    end

    // Owner under lock sees ready even while idle so its burst is never interleaved.
    always_comb begin
        ready_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(grant_s)) begin
                ready_s[k] = accept_s & ~flush & (locked_r | (pick_any_s & valid_i[k]));
            end else begin
                ready_s[k] = 1'b0;
            end
        end
    end

    // Transfer detection and lock request of the winner; one requester cannot lock.
    always_comb begin
        fire_s = |(ready_s & valid_i);
        if (NUM_REQ > 32'sd1) begin
            lock_next_s = lock_i[grant_s];
        end else begin
            lock_next_s = 1'b0;
        end
    end

    // Output register, grant history and lock state; flush outranks any transfer.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            valid_r      <= 1'b0;
            out_r        <= '0;
            out_id_r     <= '0;
            last_grant_r <= LastIdx;
            locked_r     <= 1'b0;
        end else if (flush) begin
            valid_r      <= 1'b0;
            last_grant_r <= LastIdx;
            locked_r     <= 1'b0;
        end else if (accept_s) begin
            if (fire_s) begin
                valid_r      <= 1'b1;
                out_r        <= in_s[grant_s];
                out_id_r     <= grant_s;
                last_grant_r <= grant_s;
                locked_r     <= lock_next_s;
            end else begin
                valid_r      <= 1'b0;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign ready_o = ready_s;
    assign valid_o = valid_r;
    assign out     = out_r;
    assign out_id  = out_id_r;

endmodule

// File: tb/tb_hsv_core_rr_arbiter.sv
// Scoreboard bench for hsv_core_rr_arbiter: directed scenarios plus random traffic
// against a behavioural round-robin model, and a 3-requester wrap check.
module tb_hsv_core_rr_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic                 rst_core;
    logic                 flush;
    logic [N-1:0]         valid_i;
    logic [N-1:0]         ready_o;
    logic [N-1:0][W-1:0]  in;
    logic [N-1:0]         lock_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [W-1:0]         out;
    logic [1:0]           out_id;

    logic [N3-1:0]        valid3;
    logic [N3-1:0]        ready3;
    logic [N3-1:0][W-1:0] in3;
    logic [N3-1:0]        lock3;
    logic                 ready3_i;
    logic                 valid3_o;
    logic [W-1:0]         out3;
    logic [1:0]           out_id3;
    logic                 flush3;

    hsv_core_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush),
        .valid_i(valid_i), .ready_o(ready_o), .in(in), .lock_i(lock_i),
        .ready_i(ready_i), .valid_o(valid_o), .out(out), .out_id(out_id)
    );

    hsv_core_rr_arbiter #(.WIDTH(W), .NUM_REQ(N3)) dut3 (
        .clk_core(clk_core), .rst_core(rst_core), .flush(flush3),
        .valid_i(valid3), .ready_o(ready3), .in(in3), .lock_i(lock3),
        .ready_i(ready3_i), .valid_o(valid3_o), .out(out3), .out_id(out_id3)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   id;
    } beat_t;

    beat_t exp_q[$];
    int    obs_ids[$];
    int    exp_ids[$];
    int    checks   = 0;
    int    failures = 0;

    // Behavioural model state
    int           m_last;
    bit           m_locked;
    bit           m_valid;
    logic [N-1:0] exp_ready;
    logic         exp_vo;
    bit           mon_en;
    bit           use_fixed;
    logic [N-1:0][W-1:0] fixed_in;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ids(input string name);
        bit bad;
        bad = (obs_ids.size() != exp_ids.size());
        if (!bad) begin
            for (int i = 0; i < exp_ids.size(); i++) begin
                if (obs_ids[i] != exp_ids[i]) bad = 1'b1;
            end
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s observed_count=%0d expected_count=%0d first_obs=%0d first_exp=%0d",
                     name, obs_ids.size(), exp_ids.size(),
                     (obs_ids.size() > 0) ? obs_ids[0] : -1, exp_ids[0]);
        end
        obs_ids.delete();
    endtask

    // Drive one cycle of inputs and advance the model: grant = first valid index
    // after the previous winner (mod N), or the owner while locked.
    task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] lk,
                         input logic rdy, input logic fl);
        int  g;
        bit  found;
        bit  acc;
        @(posedge clk_core);
        #1;
        valid_i = v;
        lock_i  = lk;
        ready_i = rdy;
        flush   = fl;
        for (int k = 0; k < N; k++) in[k] = use_fixed ? fixed_in[k] : $urandom();
        exp_vo = m_valid;
        acc    = !m_valid || rdy;
        g      = -1;
        found  = 1'b0;
        if (m_locked) begin
            g = m_last;
        end else begin
            for (int step = 1; step <= N; step++) begin
                if (!found && v[(m_last + step) % N]) begin
                    g     = (m_last + step) % N;
                    found = 1'b1;
                end
            end
        end
        exp_ready = '0;
        if (acc && !fl && g >= 0 && (m_locked || v[g])) exp_ready[g] = 1'b1;
        if (fl) begin
            m_valid  = 1'b0;
            m_locked = 1'b0;
            m_last   = N - 1;
        end else if (acc) begin
            if (g >= 0 && exp_ready[g] && v[g]) begin
                exp_q.push_back('{data: in[g], id: 2'(g)});
                m_valid  = 1'b1;
                m_last   = g;
                m_locked = lk[g];
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: checks handshake signals each cycle and compares presented beats with the scoreboard.
    always @(negedge clk_core) begin
        if (mon_en) begin
            checks++;
            if (ready_o !== exp_ready) begin
                failures++;
                $display("FAIL ready_o actual=%b expected=%b t=%0t", ready_o, exp_ready, $time);
            end
            checks++;
            if (valid_o !== exp_vo) begin
                failures++;
                $display("FAIL valid_o actual=%b expected=%b t=%0t", valid_o, exp_vo, $time);
            end
            if (valid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat unexpected out=%h out_id=%0d t=%0t", out, out_id, $time);
                end else begin
                    if (out !== exp_q[0].data || out_id !== exp_q[0].id) begin
                        failures++;
                        $display("FAIL beat actual=%h/%0d expected=%h/%0d t=%0t",
                                 out, out_id, exp_q[0].data, exp_q[0].id, $time);
                    end
                    if (ready_i || flush) begin
                        if (ready_i) obs_ids.push_back(int'(out_id));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] lk;
        logic         rdy;
        logic         fl;

        rst_core = 1'b1; flush = 1'b0; valid_i = '0; lock_i = '0; ready_i = 1'b1; in = '0;
        valid3 = '0; lock3 = '0; ready3_i = 1'b1; in3 = '0; flush3 = 1'b0;
        m_last = N - 1; m_locked = 1'b0; m_valid = 1'b0;
        exp_ready = '0; exp_vo = 1'b0; mon_en = 1'b0; use_fixed = 1'b0; fixed_in = '0;

        repeat (3) @(posedge clk_core);
        @(negedge clk_core);
        check_eq("reset_valid_o", 32'(valid_o), 32'd0);
        check_eq("reset_out", out, 32'd0);
        check_eq("reset_out_id", 32'(out_id), 32'd0);
        check_eq("reset_valid3_o", 32'(valid3_o), 32'd0);
        check_eq("reset_out_id3", 32'(out_id3), 32'd0);
        @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        mon_en   = 1'b1;

        // All four valid, no lock: strict rotation
        repeat (8) cycle(4'hF, 4'h0, 1'b1, 1'b0);
        drain();
        exp_ids = {0, 1, 2, 3, 0, 1, 2, 3};
        check_ids("rr_sequence");

        // Sparse requesters 1 and 3: wrap skips idle 0 and 2
        cycle(4'b0010, 4'h0, 1'b1, 1'b0);
        cycle(4'b1010, 4'h0, 1'b1, 1'b0);
        cycle(4'b1010, 4'h0, 1'b1, 1'b0);
        drain();
        exp_ids = {1, 3, 1};
        check_ids("sparse_wrap");

        // Locked burst from 2 with an idle cycle in the middle
        cycle(4'b1111, 4'b0100, 1'b1, 1'b0);
        cycle(4'b1011, 4'b0100, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0100, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        drain();
        exp_ids = {2, 2, 2, 3};
        check_ids("lock_burst");

        // Downstream stall holding 0xDEADBEEF from requester 1
        use_fixed = 1'b1;
        fixed_in  = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        cycle(4'b0010, 4'h0, 1'b1, 1'b0);
        repeat (3) cycle(4'b0001, 4'h0, 1'b0, 1'b0);
        check_eq("stall_out", out, 32'hDEAD_BEEF);
        cycle(4'b0001, 4'h0, 1'b1, 1'b0);
        drain();
        use_fixed = 1'b0;
        exp_ids = {1, 0};
        check_ids("stall_release");

        // Flush during a locked burst drops the held beat and resets priority
        cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
        cycle(4'b1111, 4'b0100, 1'b0, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b1, 1'b0);
        drain();
        exp_ids = {0};
        check_ids("flush_locked");

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            v   = N'($urandom());
            lk  = N'($urandom());
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            cycle(v, lk, rdy, fl);
        end
        cycle('0, '0, 1'b1, 1'b1);
        drain();
        obs_ids.delete();
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Three requesters: non-power-of-two wrap
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk_core);
            #1;
            valid3 = (c < 6) ? 3'b111 : 3'b000;
            for (int k = 0; k < N3; k++) in3[k] = 32'hC0DE_0000 + 32'(k);
            ready3_i = 1'b1;
            @(negedge clk_core);
            if (c < 6) check_eq("n3_ready", 32'(ready3), 32'(3'b001 << (c % 3)));
            if (c >= 1) begin
                check_eq("n3_valid", 32'(valid3_o), 32'd1);
                check_eq("n3_out_id", 32'(out_id3), 32'((c - 1) % 3));
                check_eq("n3_out", out3, 32'hC0DE_0000 + 32'((c - 1) % 3));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsv_core_rr_arbiter.md
Name: hsv_core_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream valid/ready channel between NUM_REQ upstream producers. Typical producers are hsv_core_fifo instances feeding a shared writeback or memory port. The block selects one requester per cycle, registers the winning payload together with its source index, and supports a lock so a multi-beat transfer is not interleaved. Streaming throughput is one beat per cycle with one cycle of latency.

Parameters:
WIDTH, 32, payload width in bits
NUM_REQ, 4, number of requesters (>=1, need not be a power of two)
IdBits (localparam), max(1, $clog2(NUM_REQ)), width of the source index

Ports:
clk_core  input  1  core clock
rst_core  input  1  synchronous, active-high reset
flush  input  1  drop registered beat, clear lock, reset priority
valid_i  input  NUM_REQ  per-requester beat valid
ready_o  output  NUM_REQ  per-requester accept (one-hot or zero)
in  input  NUM_REQ x WIDTH  per-requester payload
lock_i  input  NUM_REQ  per-requester: keep grant after this beat
ready_i  input  1  downstream accept
valid_o  output  1  registered beat valid
out  output  WIDTH  registered payload
out_id  output  IdBits  index of requester that produced out

Behaviour:
- Clock and reset: one clock, clk_core. Reset rst_core is synchronous and active-high.
- Reset values (sampled at posedge clk_core with rst_core=1):
  - valid_o=0, out='0, out_id='0.
  - Internal last_grant=NUM_REQ-1, locked=0.
  - After reset, requester 0 has highest priority.
- State: last_grant (IdBits), locked (1 bit). Two modes:
  - FREE (locked=0).
  - LOCKED (locked=1): grant is pinned to last_grant.
- Stage enable: accept = ~valid_o | ready_i. This is a plain pipeline register with no skid buffer.
- Grant selection (combinational):
  - FREE: grant = first index with valid_i set, scanning from last_grant+1 upward with wrap to 0 after NUM_REQ-1. Wrap is explicit (compare to NUM_REQ), not a power-of-two overflow.
  - LOCKED: grant = last_grant, regardless of other requesters' valid_i.
- ready_o:
  - ready_o[k] = accept & ~flush & (k==grant) & (FREE ? valid_i[k] : 1).
  - In LOCKED mode the owner sees ready_o high even while its valid_i is low. All other requesters see 0.
  - ready_o never depends on valid_i of the same index in LOCKED mode.
- Transfer: fires when ready_o[g] & valid_i[g]. On the next edge:
  - valid_o=1, out=in[g], out_id=g, last_grant=g, locked=lock_i[g].
- Stage enable high with no transfer: valid_o<=0; out and out_id keep their old values.
- Downstream stall (valid_o & ~ready_i): out, out_id and valid_o hold; all ready_o=0.
- Latency: input handshake at edge N makes the beat visible on out at edge N+1. Back-to-back beats every cycle while ready_i=1.
- Fairness: the requester granted last has lowest priority in the next FREE arbitration. With all NUM_REQ requesters continuously valid and lock_i=0, grants cycle 0,1,..,NUM_REQ-1,0.
- Lock release: a transfer with lock_i=0 from the owner returns the arbiter to FREE. lock_i of non-granted requesters is ignored.
- flush has priority over a transfer in the same cycle:
  - valid_o<=0, locked<=0, last_grant<=NUM_REQ-1.
  - ready_o is forced to 0 during flush, so no beat is lost silently.
- rst_core overrides flush and everything else.
- NUM_REQ=1: out_id is constantly 0, and the block degenerates to a pipeline register whose lock has no effect.

Decomposition:
- Shared package hsv_core_pkg gains no new types. IdBits stays a module localparam.
- The payload array type is declared with a local typedef.
- Sub-module hsv_core_rr_pick (purely combinational):
  - Inputs: req[NUM_REQ], last[IdBits].
  - Outputs: grant index, any.
  - Implemented as a rotate-and-priority-encode over the requests.
  - Reusable by later schedulers (issue-port arbitration).

Test Plan:
- Reset, then all four valid_i=1 with lock_i=0 and ready_i=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 starting one cycle after the first handshake; ready_o one-hot each cycle.
- Requesters 1 and 3 valid, last_grant=1 -> 3 granted; next cycle 1 granted (wrap with skip of idle 0 and 2).
- Requester 2 sends beats with lock_i=1,1,0 while 0, 1 and 3 stay valid; requester 2 idles one cycle mid-burst -> ready_o[2] stays high during the idle cycle and others get 0; out_id=2 for all three beats; next grant goes to 3.
- ready_i=0 for 3 cycles with a beat pending (out=0xDEADBEEF, out_id=1) -> outputs stable and ready_o=0; ready_i=1 -> beat consumed and the next beat follows one cycle later.
- flush asserted during a locked burst with valid_o=1 -> next cycle valid_o=0, lock cleared, requester 0 wins if valid; no ready_o during the flush cycle.
- NUM_REQ=3 instance, all requesters valid for 6 cycles -> out_id 0,1,2,0,1,2 (non-power-of-two wrap).
